// File: rtl/ex_mul_unit.sv
// Iterative 32x32 -> 64 multiplier for the execute stage: one shift-add step per
// cycle, signed operands handled as magnitudes with the sign applied at the end.
module ex_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             set_cc,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic             icc_n,
  output logic             icc_z,
  output logic             cc_valid
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nx;
  logic                 accept;
  logic                 last_step;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc, acc_nx, res;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 sign_lat;
  logic                 cc_lat;

  // Magnitude of a two's-complement value; 0x80000000 maps to itself, which is
  // the correct unsigned magnitude, so no extra bit is needed.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    if (sgn && v[WIDTH-1])
      return (~v) + WIDTH'(1);
    else
      return v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v,
                                                    input logic neg);
    if (neg)
      return (~v) + (2*WIDTH)'(1);
    else
      return v;
  endfunction

  assign last_step = (cnt == LAST_STEP);
  assign acc_nx    = acc + (mplier[0] ? mcand : '0);
  assign res       = apply_sign(acc_nx, sign_lat);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (flush)
          state_nx = IDLE;
        else if (last_step)
          state_nx = DONE;
      end
      DONE: begin
        if (start && !flush) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result registers only move on the final step, so flushes and ignored starts
  // leave the previous product visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      sign_lat <= 1'b0;
      cc_lat   <= 1'b0;
      prod_hi  <= '0;
      prod_lo  <= '0;
      icc_n    <= 1'b0;
      icc_z    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cc_lat   <= set_cc;
        sign_lat <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        mcand    <= {{WIDTH{1'b0}}, magnitude(op_a, is_signed)};
        mplier   <= magnitude(op_b, is_signed);
        acc      <= '0;
        cnt      <= '0;
      end else if (state == RUN && !flush) begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (last_step) begin
          prod_hi <= res[2*WIDTH-1:WIDTH];
          prod_lo <= res[WIDTH-1:0];
          if (cc_lat) begin
            icc_n <= res[WIDTH-1];
            icc_z <= (res[WIDTH-1:0] == '0);
          end
        end
      end
    end
  end

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign cc_valid = (state == DONE) && cc_lat;

endmodule

// File: tb/tb_ex_mul_unit.sv
// Self-checking bench for ex_mul_unit: directed corner cases plus random
// operands compared against a plain-arithmetic 64-bit product model.
module tb_ex_mul_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic        set_cc;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] prod_lo;
  logic [31:0] prod_hi;
  logic        icc_n;
  logic        icc_z;
  logic        cc_valid;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_prod = '0;
  logic        exp_n    = 1'b0;
  logic        exp_z    = 1'b0;

  ex_mul_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .set_cc(set_cc), .flush(flush), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .prod_lo(prod_lo), .prod_hi(prod_hi),
    .icc_n(icc_n), .icc_z(icc_z), .cc_valid(cc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {61'b0, busy, done, cc_valid}, 64'd0);
    check({tag, "_prod"}, {prod_hi, prod_lo}, 64'd0);
    check({tag, "_icc"}, {62'b0, icc_n, icc_z}, 64'd0);
  endtask

  // Called #1 after the accepting edge; returns #1 after the edge entering DONE.
  task automatic wait_done(input logic [63:0] exp, input logic cc, input string tag);
    int busy_n  = 0;
    int done_k  = -1;
    int overlap = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) tick();
      if (busy && done) overlap++;
      if (busy) busy_n++;
      if (done) begin
        done_k = k;
        break;
      end
    end
    exp_prod = exp;
    if (cc) begin
      exp_n = exp[31];
      exp_z = (exp[31:0] == 32'd0);
    end
    check({tag, "_done_cycle"}, 64'(done_k + 1), 64'd33);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd32);
    check({tag, "_busy_done_overlap"}, 64'(overlap), 64'd0);
    check({tag, "_prod"}, {prod_hi, prod_lo}, exp_prod);
    check({tag, "_cc_valid"}, {63'b0, cc_valid}, {63'b0, cc});
    check({tag, "_icc"}, {62'b0, icc_n, icc_z}, {62'b0, exp_n, exp_z});
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic cc, input string tag);
    op_a = a; op_b = b; is_signed = sgn; set_cc = cc; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(ref_mul(a, b, sgn), cc, tag);
  endtask

  initial begin
    int ndone;
    logic [31:0] ra, rb;
    logic        rs, rc;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; set_cc = 1'b0; flush = 1'b0;
    op_a = '0; op_b = '0;

    repeat (2) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "umul_max");
    check("umul_max_const", {prod_hi, prod_lo}, 64'hFFFF_FFFE_0000_0001);
    tick();

    run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b1, "smulcc_m3x7");
    check("smulcc_m3x7_const", {prod_hi, prod_lo, 30'b0, icc_n, icc_z},
          {32'hFFFF_FFFF, 32'hFFFF_FFEB, 30'b0, 1'b1, 1'b0});
    tick();

    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, "smulcc_minmin");
    check("smulcc_minmin_const", {prod_hi, prod_lo, 30'b0, icc_n, icc_z},
          {32'h4000_0000, 32'h0, 30'b0, 1'b0, 1'b1});

    // Flush arriving in the DONE cycle: pulse completes, start is refused.
    start = 1'b1; flush = 1'b1; op_a = 32'd3; op_b = 32'd3;
    check("flush_in_done_pulse", {63'b0, done}, 64'd1);
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_in_done_no_accept", {62'b0, busy, done}, 64'd0);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom; rb = $urandom;
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      if (i == 0) ra = 32'd0;
      if (i == 1) rb = 32'h7FFF_FFFF;
      run_op(ra, rb, rs, rc, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    op_a = 32'd1234; op_b = 32'd5678; is_signed = 1'b0; set_cc = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_run_busy", {62'b0, busy, done}, 64'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || cc_valid || busy) ndone++;
    end
    check("flush_run_no_done", 64'(ndone), 64'd0);
    check("flush_run_prod_held", {prod_hi, prod_lo}, exp_prod);
    check("flush_run_icc_held", {62'b0, icc_n, icc_z}, {62'b0, exp_n, exp_z});

    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("start_flush_idle", {62'b0, busy, done}, 64'd0);
    tick();
    check("start_flush_idle_later", {62'b0, busy, done}, 64'd0);
    check("start_flush_prod_held", {prod_hi, prod_lo}, exp_prod);

    // Start held through RUN is ignored; still high in DONE it chains the next op.
    op_a = 32'hDEAD_BEEF; op_b = 32'hFFFF_FF00; is_signed = 1'b1; set_cc = 1'b1;
    start = 1'b1;
    tick();
    op_a = 32'd40000; op_b = 32'h0001_0001; is_signed = 1'b0; set_cc = 1'b0;
    wait_done(ref_mul(32'hDEAD_BEEF, 32'hFFFF_FF00, 1'b1), 1'b1, "held_first");
    tick();
    start = 1'b0;
    wait_done(ref_mul(32'd40000, 32'h0001_0001, 1'b0), 1'b0, "b2b_second");

    tick();
    op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; is_signed = 1'b0; set_cc = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    #1 rst_n = 1'b0;
    #1;
    check_zero("async_reset_mid_run");
    exp_prod = '0; exp_n = 1'b0; exp_z = 1'b0;
    tick();
    check_zero("reset_held");
    rst_n = 1'b1;
    tick();
    run_op(32'd5, 32'd6, 1'b0, 1'b0, "umul_5x6");
    check("umul_5x6_const", {prod_hi, prod_lo}, 64'd30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_mul_unit.md
EX_MUL_UNIT -- requirements
Module: ex_mul_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width; only 32 is supported, and the step counter width is derived as clog2(WIDTH).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  in  1  request a multiply; sampled on the rising edge.
REQ-005 SHALL have port: is_signed  in  1  1 = SMUL (two's complement), 0 = UMUL; sampled with start.
REQ-006 SHALL have port: set_cc  in  1  1 = SMULcc/UMULcc; sampled with start.
REQ-007 SHALL have port: flush  in  1  abort any operation in progress (pipeline squash).
REQ-008 SHALL have port: op_a  in  32  rs1 value; sampled with start.
REQ-009 SHALL have port: op_b  in  32  operand2 N from the source-operand stage; sampled with start.
REQ-010 SHALL have port: busy  out  1  high while state = RUN; used as pipeline stall.
REQ-011 SHALL have port: done  out  1  one-cycle pulse; product valid.
REQ-012 SHALL have port: prod_lo  out  32  product bits 31:0, written to rd.
REQ-013 SHALL have port: prod_hi  out  32  product bits 63:32, written to Y.
REQ-014 SHALL have port: icc_n  out  1  negative flag, equal to prod_lo[31].
REQ-015 SHALL have port: icc_z  out  1  zero flag, high when prod_lo == 0.
REQ-016 SHALL have port: cc_valid  out  1  pulse coincident with done when set_cc was latched.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-018 SHALL accept start when state is IDLE or DONE and flush = 0; on acceptance it latches is_signed and set_cc, latches the operand magnitudes (absolute value when is_signed = 1, raw value otherwise), latches the result sign (op_a[31] XOR op_b[31], only when signed), clears the step counter, and enters RUN.
REQ-019 SHALL ignore start while in RUN, with no effect on the operation in progress.
REQ-020 SHALL perform one shift-add step per edge in RUN (a 64-bit accumulator using the multiplier LSB) and enter DONE after the edge where the step counter equals 31, i.e. 32 RUN edges.
REQ-021 SHALL, on the edge entering DONE, load prod_hi and prod_lo with the accumulator, two's-complement negated over 64 bits when the latched sign = 1; icc_n and icc_z are updated from the new prod_lo on the same edge only when set_cc was latched.
REQ-022 SHALL, while in DONE, drive done = 1 (and cc_valid = latched set_cc) for exactly one cycle, then return to IDLE unless a new start is accepted in that cycle.
REQ-023 SHALL produce done on the 33rd cycle after the accepting edge; busy SHALL be 1 for exactly 32 cycles.
REQ-024 SHALL hold prod_hi, prod_lo, icc_n and icc_z unchanged until the next DONE entry, including across flushes and across a start that is not accepted.
REQ-025 SHALL, when flush = 1 in RUN, enter IDLE on the next edge, drop busy, and produce no done or cc_valid.
REQ-026 SHALL, when flush = 1 in DONE, still complete the done pulse (the result has already been produced) but accept no start that cycle.
REQ-027 SHALL, when start = 1 and flush = 1 in the same cycle, give flush priority: start is not accepted.
REQ-028 SHALL produce the exact 64-bit result for SMUL 0x80000000 × 0x80000000, i.e. 0x40000000_00000000, using 32-bit unsigned magnitudes without overflow.
REQ-029 SHALL never assert done and busy in the same cycle.

Reset
REQ-030 SHALL, when rst_n = 0, immediately (asynchronously) force state = IDLE and busy, done, cc_valid, icc_n, icc_z, prod_hi, prod_lo and the internal accumulator and counter to 0, including in the middle of a RUN.
REQ-031 SHALL, after rst_n deasserts, accept start no earlier than the first rising edge.

Verification
REQ-032 SHALL cover: UMUL 0xFFFFFFFF × 0xFFFFFFFF -> prod_hi = 0xFFFFFFFE, prod_lo = 0x00000001, done exactly 33 cycles after acceptance, busy high for 32 cycles.
REQ-033 SHALL cover: SMULcc −3 × 7 -> prod_hi = 0xFFFFFFFF, prod_lo = 0xFFFFFFEB, icc_n = 1, icc_z = 0, cc_valid = 1 with done.
REQ-034 SHALL cover: SMULcc 0x80000000 × 0x80000000 -> prod_hi = 0x40000000, prod_lo = 0, icc_z = 1, icc_n = 0.
REQ-035 SHALL cover: flush at RUN step 10 -> busy = 0 on the next edge, no done pulse, prod_hi and prod_lo keep the prior result; start + flush together in IDLE -> not accepted.
REQ-036 SHALL cover: start held during RUN is ignored; start asserted in the DONE cycle -> back-to-back accept, second done 33 cycles later with the correct second product.
REQ-037 SHALL cover: rst_n low at RUN step 20 -> all outputs 0 without waiting for a clock edge; UMUL 5 × 6 after release -> prod_lo = 30, prod_hi = 0.
